// File: rtl/octa_pkg.sv
// Shared definitions for the octa datapath: ALU opcodes, instruction field
// positions, register index type and the instruction field decoder.
package octa_pkg;

  localparam int INSTR_W   = 16;
  localparam int XLEN      = 8;
  localparam int REG_IDX_W = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_LOG  = 3'b001;
  localparam logic [2:0] ALU_SLTU = 3'b010;
  localparam logic [2:0] ALU_SH   = 3'b011;
  localparam logic [2:0] ALU_SRA  = 3'b100;

  localparam int CTRL_HI    = 15;
  localparam int CTRL_LO    = 13;
  localparam int FLAG_BIT   = 12;
  localparam int RD_HI      = 11;
  localparam int RD_LO      = 9;
  localparam int RS1_HI     = 8;
  localparam int RS1_LO     = 6;
  localparam int IMMSEL_BIT = 5;
  localparam int RS2_HI     = 4;
  localparam int RS2_LO     = 2;
  localparam int IMM_HI     = 4;
  localparam int IMM_LO     = 0;

  typedef struct packed {
    logic [2:0] ctrl;
    logic       flag;
    reg_idx_t   rd;
    reg_idx_t   rs1;
    logic       imm_sel;
    reg_idx_t   rs2;
    logic [4:0] imm;
  } dec_t;

  function automatic dec_t decode_instr(input logic [INSTR_W-1:0] ins);
    dec_t d;
    d.ctrl    = ins[CTRL_HI:CTRL_LO];
    d.flag    = ins[FLAG_BIT];
    d.rd      = ins[RD_HI:RD_LO];
    d.rs1     = ins[RS1_HI:RS1_LO];
    d.imm_sel = ins[IMMSEL_BIT];
    d.rs2     = ins[RS2_HI:RS2_LO];
    d.imm     = ins[IMM_HI:IMM_LO];
    return d;
  endfunction

  // Opcodes above SRA have no ALU meaning and are trapped in decode.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= ALU_SRA);
  endfunction

endpackage

// File: rtl/regfile.sv
// 8x8 register file: two asynchronous read ports, one synchronous write port,
// r0 reads as zero and ignores writes.
module regfile
  import octa_pkg::*;
#(
  parameter int NREG   = 8,
  parameter int DATA_W = XLEN,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_ra1,
  input  logic [IDX_W-1:0]  i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage feeding the 8-bit ALU, with a write scoreboard
// for RAW stalls. Define DECODE_BYPASS_EN to forward same-cycle writeback data.
module decode_stage
  import octa_pkg::*;
#(
  parameter int NREG   = 8,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    ex_rs1,
  output logic [XLEN-1:0]    ex_rs2,
  output logic [2:0]         ex_ctrl,
  output logic               ex_flag,
  output logic [IDX_W-1:0]   ex_rd,
  output logic               ex_wen,
  input  logic               wb_en,
  input  logic [IDX_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               illegal
);

  localparam int DATA_W = XLEN;

  dec_t              w_dec_p0;
  logic              w_legal_p0;
  logic              w_byp1_p0;
  logic              w_byp2_p0;
  logic              w_haz_p0;
  logic              w_out_free_p0;
  logic              w_acc_p0;
  logic              w_issue_p0;
  logic              w_wen_p0;
  logic [DATA_W-1:0] w_rf1_p0;
  logic [DATA_W-1:0] w_rf2_p0;
  logic signed [DATA_W-1:0] w_op1_p0;
  logic signed [DATA_W-1:0] w_op2_p0;
  logic [NREG-1:0]   w_pend_nxt;

  logic [NREG-1:0]   r_pend;
  logic              r_vld_p1;
  logic signed [DATA_W-1:0] r_rs1_p1;
  logic signed [DATA_W-1:0] r_rs2_p1;
  logic [2:0]        r_ctrl_p1;
  logic              r_flag_p1;
  logic [IDX_W-1:0]  r_rd_p1;
  logic              r_wen_p1;
  logic              r_ill_p1;

  // A source only blocks issue when it is waiting on a write that is not
  // being forwarded this cycle.
  function automatic logic src_blocked(input logic pend, input logic byp);
    return pend && !byp;
  endfunction

  // Stage p0: decode, operand read, hazard detection
  assign w_dec_p0   = decode_instr(in_instr);
  assign w_legal_p0 = is_legal_op(w_dec_p0.ctrl);
  assign w_wen_p0   = (w_dec_p0.rd != '0);

  regfile #(.NREG(NREG), .DATA_W(DATA_W)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_dec_p0.rs1),
    .i_ra2 (w_dec_p0.rs2),
    .o_rd1 (w_rf1_p0),
    .o_rd2 (w_rf2_p0),
    .i_we  (wb_en),
    .i_wa  (wb_rd),
    .i_wd  (wb_data)
  );

`ifdef DECODE_BYPASS_EN
  assign w_byp1_p0 = wb_en && (wb_rd == w_dec_p0.rs1) && (w_dec_p0.rs1 != '0);
  assign w_byp2_p0 = wb_en && (wb_rd == w_dec_p0.rs2) && (w_dec_p0.rs2 != '0);
`else
  assign w_byp1_p0 = 1'b0;
  assign w_byp2_p0 = 1'b0;
`endif

  assign w_op1_p0 = w_byp1_p0 ? wb_data : w_rf1_p0;
  assign w_op2_p0 = w_dec_p0.imm_sel ? {3'b000, w_dec_p0.imm}
                                     : (w_byp2_p0 ? wb_data : w_rf2_p0);

  assign w_haz_p0 = src_blocked(r_pend[w_dec_p0.rs1], w_byp1_p0) ||
                    (!w_dec_p0.imm_sel && src_blocked(r_pend[w_dec_p0.rs2], w_byp2_p0));

  // Illegal opcodes never read operands, so they are not held back by hazards.
  assign w_out_free_p0 = !r_vld_p1 || ex_ready;
  assign in_ready      = !rst && w_out_free_p0 && (!w_legal_p0 || !w_haz_p0);
  assign w_acc_p0      = in_valid && in_ready;
  assign w_issue_p0    = w_acc_p0 && w_legal_p0;

  always_comb begin
    w_pend_nxt = r_pend;
    if (wb_en) w_pend_nxt[wb_rd] = 1'b0;
    if (w_issue_p0 && w_wen_p0) w_pend_nxt[w_dec_p0.rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_nxt;
  end

  // Stage p1: ALU-facing output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_ill_p1 <= 1'b0;
    end else begin
      r_ill_p1 <= w_acc_p0 && !w_legal_p0;
      if (w_issue_p0)    r_vld_p1 <= 1'b1;
      else if (ex_ready) r_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1_p1  <= '0;
      r_rs2_p1  <= '0;
      r_ctrl_p1 <= '0;
      r_flag_p1 <= 1'b0;
      r_rd_p1   <= '0;
      r_wen_p1  <= 1'b0;
    end else if (w_issue_p0) begin
      r_rs1_p1  <= w_op1_p0;
      r_rs2_p1  <= w_op2_p0;
      r_ctrl_p1 <= w_dec_p0.ctrl;
      r_flag_p1 <= w_dec_p0.flag;
      r_rd_p1   <= w_dec_p0.rd;
      r_wen_p1  <= w_wen_p0;
    end
  end

  assign ex_valid = r_vld_p1;
  assign ex_rs1   = r_rs1_p1;
  assign ex_rs2   = r_rs2_p1;
  assign ex_ctrl  = r_ctrl_p1;
  assign ex_flag  = r_flag_p1;
  assign ex_rd    = r_rd_p1;
  assign ex_wen   = r_wen_p1;
  assign illegal  = r_ill_p1;

endmodule
